pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised successor to the fixed EX/MEM pipeline register. Carries one instruction bundle (op, func, result, rd, wrReg) between two pipeline stages using a valid/ready handshake. A 2-entry skid buffer keeps in_ready registered, and a flush input injects bubbles. Instantiated at each stage boundary in place of the hand-written per-stage registers.

Parameters:
DBITS, 32, width of the result/data field
REG_INDEX_BIT_WIDTH, 4, width of the destination register index
OPBITS, 4, width of the op and func fields
CNT_BITS, 16, width of the stall counter (used only with PIPE_STALL_CNT_EN)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
flush  in  1  discard all held entries; synchronous, one-cycle pulse
in_valid  in  1  upstream bundle valid
in_ready  out  1  buffer can accept this cycle
in_op  in  OPBITS  opcode
in_func  in  OPBITS  function code
in_result  in  DBITS  ALU result / data
in_rd  in  REG_INDEX_BIT_WIDTH  destination register
in_wrReg  in  1  register write request
out_valid  out  1  output bundle valid
out_ready  in  1  downstream accepts this cycle
out_op  out  OPBITS  held opcode
out_func  out  OPBITS  held function code
out_result  out  DBITS  held result
out_rd  out  REG_INDEX_BIT_WIDTH  held destination
out_wrReg  out  1  held write request, gated by out_valid
stall_cnt  out  CNT_BITS  stall cycle count (only with PIPE_STALL_CNT_EN)

Behaviour:
- Storage:
  - main slot drives out_*.
  - skid slot holds one overflow bundle.
  - state is EMPTY, ONE or TWO.
- Handshake:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Decodes:
  - in_ready = reset & (state != TWO); driven from the state register, with no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- Latency: a bundle accepted at edge N is visible on out_* after edge N, so out_valid is high in cycle N+1.
- Transitions when flush=0:
  - EMPTY: accept → ONE, main <= in. No accept → stay.
  - ONE: accept & pop → ONE, main <= in. Pop only → EMPTY. Accept only → TWO, skid <= in. Neither → stay.
  - TWO: pop → ONE, main <= skid. No pop → stay. No accept is possible because in_ready=0.
- Ordering: strict FIFO; no bundle is dropped or duplicated.
- Hold: while out_ready=0, out_* stay stable and are not overwritten.
- out_wrReg = main_wrReg & out_valid, so bubbles never request a write.
- Flush (reset high, flush=1):
  - state → EMPTY; any bundle presented in the same cycle is discarded.
  - flush has priority over accept and pop.
  - data fields need not be cleared.
  - in_ready is high in the following cycle.
- Reset (reset=0 at edge):
  - state → EMPTY.
  - out_op, out_func, out_result, out_rd and out_wrReg → 0; out_valid → 0.
  - in_ready = 0 while reset is low.
  - reset overrides flush and handshakes.
  - Reset mid-operation discards both slots.
- No arithmetic is performed on data fields; they are passed bit-exact.

Optional Feature:
PIPE_STALL_CNT_EN
- Defined:
  - stall_cnt port exists.
  - Increments by 1 each cycle with out_valid=1 & out_ready=0.
  - Saturates at all-ones.
  - Cleared to 0 by reset; not cleared by flush.
- Undefined: the stall_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
1. Basic pass-through: reset=1, out_ready=1; drive op=0xC, func=0x7, result=2, rd=3, wrReg=1, in_valid=1 for one cycle → next cycle out_valid=1 with out_op=0xC, out_func=0x7, out_result=2, out_rd=3, out_wrReg=1; the cycle after, out_valid=0.
2. Backpressure fill: out_ready=0; push result=2, then result=5 → state TWO, in_ready=0, out_result=2 held. Raise out_ready → out_result=2, then 5, in order; in_ready returns to 1 after the first pop.
3. Streaming: out_ready=1, in_valid=1 for 8 cycles with result=0..7 → out_result=0..7 on consecutive cycles; in_ready never drops.
4. Flush: with two entries held (result=2, 5), pulse flush while presenting result=9 → next cycle out_valid=0, out_wrReg=0, in_ready=1; 9 never appears at the output.
5. Reset mid-operation: state ONE holding rd=3; drive reset=0 for one edge → all out_* = 0, out_valid=0, in_ready=0 during reset; after release, in_ready=1 and the first new push appears normally.
6. Stall counter (PIPE_STALL_CNT_EN defined): hold one entry with out_ready=0 for 5 cycles → stall_cnt=5. Flush → still 5. Reset → 0. With CNT_BITS=2, hold for 6 stalls → stall_cnt saturates at 3.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer and a flush input.
// Optional stall cycle counter on the stall_cnt port, enabled by defining PIPE_STALL_CNT_EN.
//
// state | meaning
// EMPTY | no bundle held, out_valid low
// ONE   | main slot holds the output bundle
// TWO   | main and skid slots both full, in_ready low
module pipe_stage_reg #(
  parameter int DBITS               = 32,
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int OPBITS              = 4,
  parameter int CNT_BITS            = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [OPBITS-1:0]              in_op,
  input  logic [OPBITS-1:0]              in_func,
  input  logic [DBITS-1:0]               in_result,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] in_rd,
  input  logic                           in_wrReg,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OPBITS-1:0]              out_op,
  output logic [OPBITS-1:0]              out_func,
  output logic [DBITS-1:0]               out_result,
  output logic [REG_INDEX_BIT_WIDTH-1:0] out_rd,
  output logic                           out_wrReg
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_BITS-1:0]            stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_t;

  typedef struct packed {
    logic [OPBITS-1:0]              op;
    logic [OPBITS-1:0]              func;
    logic [DBITS-1:0]               result;
    logic [REG_INDEX_BIT_WIDTH-1:0] rd;
    logic                           wr_reg;
  } bundle_t;

  state_t  state_q, state_d;
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  bundle_t in_bundle;
  logic    accept;
  logic    pop;

  assign in_bundle = '{op: in_op, func: in_func, result: in_result, rd: in_rd, wr_reg: in_wrReg};
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Flush only empties the FSM; slot contents are left as-is since out_valid masks them.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_bundle;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_bundle;
          end else if (pop) begin
            state_d = EMPTY;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = in_bundle;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready   = reset & (state_q != TWO);
    out_valid  = (state_q != EMPTY);
    out_op     = main_q.op;
    out_func   = main_q.func;
    out_result = main_q.result;
    out_rd     = main_q.rd;
    out_wrReg  = main_q.wr_reg & out_valid;
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_BITS-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_BITS{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic [CNT_BITS-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + randomised bench for pipe_stage_reg using a FIFO scoreboard model.
// Define PIPE_STALL_CNT_EN to also exercise the stall counter (incl. a CNT_BITS=2 instance).
module tb_pipe_stage_reg;

  localparam int DB = 32;
  localparam int RB = 4;
  localparam int OB = 4;
  localparam int CB = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [OB-1:0] in_op = '0;
  logic [OB-1:0] in_func = '0;
  logic [DB-1:0] in_result = '0;
  logic [RB-1:0] in_rd = '0;
  logic          in_wrReg = 1'b0;

  logic          in_ready;
  logic          out_valid;
  logic [OB-1:0] out_op;
  logic [OB-1:0] out_func;
  logic [DB-1:0] out_result;
  logic [RB-1:0] out_rd;
  logic          out_wrReg;

  typedef struct packed {
    logic [OB-1:0] op;
    logic [OB-1:0] func;
    logic [DB-1:0] res;
    logic [RB-1:0] rd;
    logic          wr;
  } bundle_t;

  bundle_t q[$];
  int      errors = 0;
  int      checks = 0;

  always #5 clk = ~clk;

`ifdef PIPE_STALL_CNT_EN
  logic [CB-1:0] stall_cnt;
  logic [1:0]    s_stall_cnt;
  logic          s_in_ready, s_out_valid, s_out_wrReg;
  logic [OB-1:0] s_out_op, s_out_func;
  logic [DB-1:0] s_out_result;
  logic [RB-1:0] s_out_rd;
  logic [CB-1:0] m_stall = '0;
  logic [1:0]    m_stall2 = '0;

  pipe_stage_reg #(.DBITS(DB), .REG_INDEX_BIT_WIDTH(RB), .OPBITS(OB), .CNT_BITS(2)) u_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_func(in_func), .in_result(in_result), .in_rd(in_rd), .in_wrReg(in_wrReg),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_op(s_out_op), .out_func(s_out_func),
    .out_result(s_out_result), .out_rd(s_out_rd), .out_wrReg(s_out_wrReg), .stall_cnt(s_stall_cnt)
  );
`endif

  pipe_stage_reg #(.DBITS(DB), .REG_INDEX_BIT_WIDTH(RB), .OPBITS(OB), .CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_func(in_func), .in_result(in_result), .in_rd(in_rd), .in_wrReg(in_wrReg),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_func(out_func),
    .out_result(out_result), .out_rd(out_rd), .out_wrReg(out_wrReg)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int op, input int func, input int res,
                       input int rd, input logic wr);
    in_valid  = v;
    in_op     = op[OB-1:0];
    in_func   = func[OB-1:0];
    in_result = res[DB-1:0];
    in_rd     = rd[RB-1:0];
    in_wrReg  = wr;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic tick();
    bundle_t h;
    logic    acc;
    logic    pop;
    @(negedge clk);
    chk("in_ready", {63'd0, in_ready}, {63'd0, (reset && q.size() < 2)});
    chk("out_valid", {63'd0, out_valid}, {63'd0, (q.size() != 0)});
    if (q.size() != 0) begin
      h = q[0];
      chk("out_op", 64'(out_op), 64'(h.op));
      chk("out_func", 64'(out_func), 64'(h.func));
      chk("out_result", 64'(out_result), 64'(h.res));
      chk("out_rd", 64'(out_rd), 64'(h.rd));
      chk("out_wrReg", 64'(out_wrReg), 64'(h.wr));
    end else begin
      chk("out_wrReg_bubble", 64'(out_wrReg), 64'd0);
    end
`ifdef PIPE_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("stall_cnt_sat", 64'(s_stall_cnt), 64'(m_stall2));
`endif
    acc = in_valid && reset && (q.size() < 2);
    pop = (q.size() != 0) && out_ready;
    @(posedge clk);
`ifdef PIPE_STALL_CNT_EN
    if (!reset) begin
      m_stall  = '0;
      m_stall2 = '0;
    end else if (q.size() != 0 && !out_ready) begin
      if (m_stall != '1) m_stall = m_stall + 1'b1;
      if (m_stall2 != '1) m_stall2 = m_stall2 + 1'b1;
    end
`endif
    if (!reset || flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{op: in_op, func: in_func, res: in_result, rd: in_rd, wr: in_wrReg});
    end
    #1;
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tick();
    reset = 1'b1;
    tick();

    // basic pass-through
    out_ready = 1'b1;
    drive(1'b1, 'hC, 'h7, 2, 3, 1'b1);
    tick();
    idle();
    tick();
    tick();

    // backpressure fill, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 1, 2, 2, 4, 1'b0);
    tick();
    drive(1'b1, 3, 4, 5, 6, 1'b1);
    tick();
    drive(1'b1, 5, 5, 'hDEAD, 7, 1'b1);
    tick();
    idle();
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    tick();

    // streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i, 15 - i, i, i, i[0]);
      tick();
    end
    idle();
    tick();
    tick();

    // flush from TWO while presenting 9, then from ONE while presenting 9
    out_ready = 1'b0;
    drive(1'b1, 1, 1, 2, 1, 1'b1);
    tick();
    drive(1'b1, 2, 2, 5, 2, 1'b1);
    tick();
    drive(1'b1, 9, 9, 9, 9, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    tick();
    drive(1'b1, 4, 4, 8, 4, 1'b1);
    tick();
    drive(1'b1, 9, 9, 9, 9, 1'b1);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    tick();

    // reset mid-operation
    out_ready = 1'b0;
    drive(1'b1, 6, 6, 'h1234, 3, 1'b1);
    tick();
    idle();
    reset = 1'b0;
    tick();
    #3;
    chk("rst_out_op", 64'(out_op), 64'd0);
    chk("rst_out_func", 64'(out_func), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    chk("rst_out_wrReg", 64'(out_wrReg), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 'hA, 'hB, 'h55, 5, 1'b1);
    tick();
    idle();
    tick();
    tick();

`ifdef PIPE_STALL_CNT_EN
    // stall counter: 5 stalls, flush keeps the value, reset clears it
    reset = 1'b0;
    tick();
    reset = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 1, 1, 77, 1, 1'b1);
    tick();
    idle();
    repeat (5) tick();
    #3;
    chk("stall_cnt_five", 64'(stall_cnt), 64'd5);
    chk("stall_cnt_sat_at3", 64'(s_stall_cnt), 64'd3);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    #3;
    chk("stall_cnt_after_flush", 64'(stall_cnt), 64'd5);
    reset = 1'b0;
    tick();
    #3;
    chk("stall_cnt_after_reset", 64'(stall_cnt), 64'd0);
    reset = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 2, 2, 88, 2, 1'b0);
    tick();
    idle();
    repeat (6) tick();
    #3;
    chk("stall_cnt_sat_six", 64'(s_stall_cnt), 64'd3);
    chk("stall_cnt_six", 64'(stall_cnt), 64'd6);
    out_ready = 1'b1;
    tick();
`endif

    // randomised traffic with occasional flush and backpressure
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
